mem_controller: RTL and testbench

- Frame-buffer controller for the camera → processing → VGA video path.
- Stores one 640x480 frame of 12-bit RGB444 pixels in a single inferred single-port block RAM.
- The RAM is shared by three clients through a fixed 4-phase time-slot arbiter on sys_clk:
  - OV7670-style camera byte stream (write).
  - VGA scan-out (read).
  - Processing (ALU) unit (streaming window read plus random write).

---
 rtl/mem_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// mem_controller: single-port frame buffer shared by camera, VGA and ALU clients.
// A free-running 2-bit slot counter gives each client one RAM access per round:
//   slot 0 camera write, slot 1 VGA read, slot 2 ALU scan read, slot 3 ALU write.
// Ports:
//   sys_clk, rst (async, active low)
//   pclk, vsync_cam, href_cam, wdata_cam : camera byte stream, sampled as data
//   raddr_vga / rdata_vga                : VGA scan-out address and pixel
//   raddr_alu                            : current ALU scan address
//   waddr_alu, wdata_alu, wen_alu        : ALU random write request
//   rdata_alu                            : DWSS-tall vertical window, slice k = k lines above
module mem_controller #(
   parameter int AWIDTH = 19,
   parameter int DWIDTH = 12,
   parameter int DWSS   = 3,
   parameter int H_RES  = 640,
   parameter int V_RES  = 480
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic                    pclk,
   input  logic                    vsync_cam,
   input  logic                    href_cam,
   input  logic [7:0]              wdata_cam,
   input  logic [AWIDTH-1:0]       raddr_vga,
   output logic [DWIDTH-1:0]       rdata_vga,
   output logic [AWIDTH-1:0]       raddr_alu,
   input  logic [AWIDTH-1:0]       waddr_alu,
   input  logic [DWIDTH-1:0]       wdata_alu,
   input  logic                    wen_alu,
   output logic [DWSS*DWIDTH-1:0]  rdata_alu
);

   localparam int                FRAME     = H_RES * V_RES;
   localparam int                DEPTH     = 1 << AWIDTH;
   localparam int                LBW       = $clog2(H_RES);
   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(FRAME - 1);
   localparam logic [LBW-1:0]    LAST_COL  = LBW'(H_RES - 1);

   typedef enum logic [1:0] {
      PH_CAM    = 2'd0,
      PH_VGA    = 2'd1,
      PH_ALU_RD = 2'd2,
      PH_ALU_WR = 2'd3
   } phase_e;

   phase_e ph_q, ph_d;

   // camera synchronizers: {pclk, vsync, href, byte}
   logic [10:0] sync1_q, sync2_q;
   logic        pclk_d_q;
   logic        pclk_s, vsync_s, href_s, pclk_rise;
   logic [7:0]  byte_s;

   logic [AWIDTH-1:0] cam_addr_q, cam_addr_d, cam_waddr_q, cam_waddr_d;
   logic [DWIDTH-1:0] cam_wdata_q, cam_wdata_d;
   logic [3:0]        red_q, red_d;
   logic              byte_ph_q, byte_ph_d, cam_pend_q, cam_pend_d;

   logic [AWIDTH-1:0] alu_waddr_q;
   logic [DWIDTH-1:0] alu_wdata_q;
   logic              alu_pend_q;

   logic [AWIDTH-1:0] ram_addr;
   logic [DWIDTH-1:0] ram_wdata, ram_q;
   logic              ram_we;
   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH-1:0]      raddr_alu_q;
   logic [DWIDTH-1:0]      rdata_vga_q;
   logic [DWSS*DWIDTH-1:0] rdata_alu_q;
   logic [DWIDTH-1:0]      lb_q [DWSS-1][H_RES];
   logic [LBW-1:0]         lb_ptr_q;

   assign pclk_s    = sync2_q[10];
   assign vsync_s   = sync2_q[9];
   assign href_s    = sync2_q[8];
   assign byte_s    = sync2_q[7:0];
   assign pclk_rise = pclk_s & ~pclk_d_q;

   assign rdata_vga = rdata_vga_q;
   assign raddr_alu = raddr_alu_q;
   assign rdata_alu = rdata_alu_q;

   // slot counter next state
   always_comb begin
      ph_d = PH_CAM;
      case (ph_q)
         PH_CAM:    ph_d = PH_VGA;
         PH_VGA:    ph_d = PH_ALU_RD;
         PH_ALU_RD: ph_d = PH_ALU_WR;
         PH_ALU_WR: ph_d = PH_CAM;
         default:   ph_d = PH_CAM;
      endcase
   end

   // camera byte assembly; a pending pixel is consumed by the slot-0 write
   always_comb begin
      cam_addr_d  = cam_addr_q;
      byte_ph_d   = byte_ph_q;
      red_d       = red_q;
      cam_wdata_d = cam_wdata_q;
      cam_waddr_d = cam_waddr_q;
      cam_pend_d  = cam_pend_q & (ph_q != PH_CAM);
      if (vsync_s) begin
         cam_addr_d = '0;
         byte_ph_d  = 1'b0;
         cam_pend_d = 1'b0;
      end else if (!href_s) begin
         byte_ph_d = 1'b0;
      end else if (pclk_rise) begin
         if (!byte_ph_q) begin
            red_d     = byte_s[3:0];
            byte_ph_d = 1'b1;
         end else begin
            // a newer pixel overrides the clear above: it still needs its own write
            cam_wdata_d = DWIDTH'({red_q, byte_s});
            cam_waddr_d = cam_addr_q;
            cam_pend_d  = 1'b1;
            cam_addr_d  = (cam_addr_q == LAST_ADDR) ? '0 : cam_addr_q + AWIDTH'(1);
            byte_ph_d   = 1'b0;
         end
      end else begin
         byte_ph_d = byte_ph_q;
      end
   end

   // RAM port multiplexer driven by the slot counter
   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      case (ph_q)
         PH_CAM: begin
            ram_addr  = cam_waddr_q;
            ram_we    = cam_pend_q;
            ram_wdata = cam_wdata_q;
         end
         PH_VGA:    ram_addr = raddr_vga;
         PH_ALU_RD: ram_addr = raddr_alu_q;
         PH_ALU_WR: begin
            ram_addr  = alu_waddr_q;
            ram_we    = alu_pend_q;
            ram_wdata = alu_wdata_q;
         end
         default: ram_addr = '0;
      endcase
   end

   // block RAM, read-first, one-cycle read latency; left unreset for inference
   always_ff @(posedge sys_clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_q <= mem[ram_addr];
   end

   // slot counter, synchronizers and camera state registers
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         ph_q        <= PH_CAM;
         sync1_q     <= '0;
         sync2_q     <= '0;
         pclk_d_q    <= 1'b0;
         cam_addr_q  <= '0;
         cam_waddr_q <= '0;
         cam_wdata_q <= '0;
         red_q       <= '0;
         byte_ph_q   <= 1'b0;
         cam_pend_q  <= 1'b0;
      end else begin
         ph_q        <= ph_d;
         sync1_q     <= {pclk, vsync_cam, href_cam, wdata_cam};
         sync2_q     <= sync1_q;
         pclk_d_q    <= pclk_s;
         cam_addr_q  <= cam_addr_d;
         cam_waddr_q <= cam_waddr_d;
         cam_wdata_q <= cam_wdata_d;
         red_q       <= red_d;
         byte_ph_q   <= byte_ph_d;
         cam_pend_q  <= cam_pend_d;
      end
   end

   // ALU write capture; a capture in the same cycle as the slot-3 write stays pending
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         alu_waddr_q <= '0;
         alu_wdata_q <= '0;
         alu_pend_q  <= 1'b0;
      end else if (wen_alu) begin
         alu_waddr_q <= waddr_alu;
         alu_wdata_q <= wdata_alu;
         alu_pend_q  <= 1'b1;
      end else if (ph_q == PH_ALU_WR) begin
         alu_pend_q <= 1'b0;
      end else begin
         alu_pend_q <= alu_pend_q;
      end
   end

   // read-side outputs: VGA data, ALU scan address, line buffers and window
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         rdata_vga_q <= '0;
         raddr_alu_q <= '0;
         rdata_alu_q <= '0;
         lb_ptr_q    <= '0;
         for (int k = 0; k < DWSS - 1; k++) begin
            for (int i = 0; i < H_RES; i++) begin
               lb_q[k][i] <= '0;
            end
         end
      end else begin
         if (ph_q == PH_ALU_RD) begin
            rdata_vga_q <= ram_q;
            raddr_alu_q <= (raddr_alu_q == LAST_ADDR) ? '0 : raddr_alu_q + AWIDTH'(1);
         end
         if (ph_q == PH_ALU_WR) begin
            // each ring entry was written exactly H_RES scan reads ago, i.e. one line above
            rdata_alu_q[DWIDTH-1:0] <= ram_q;
            lb_q[0][lb_ptr_q]       <= ram_q;
            for (int k = 1; k < DWSS; k++) begin
               rdata_alu_q[k*DWIDTH +: DWIDTH] <= lb_q[k-1][lb_ptr_q];
            end
            for (int k = 1; k < DWSS - 1; k++) begin
               lb_q[k][lb_ptr_q] <= lb_q[k-1][lb_ptr_q];
            end
            lb_ptr_q <= (lb_ptr_q == LAST_COL) ? '0 : lb_ptr_q + LBW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with queue-based scoreboard.
// A reduced frame height keeps the ALU scan wrap within a short run.
module tb_mem_controller;

   localparam int AW = 19, DW = 12, DS = 3, HR = 640, VR = 6;
   localparam int FRAME = HR * VR;

   logic               sys_clk = 1'b0;
   logic               rst = 1'b0;
   logic               pclk = 1'b0, vsync_cam = 1'b0, href_cam = 1'b0;
   logic [7:0]         wdata_cam = 8'h00;
   logic [AW-1:0]      raddr_vga = '0, waddr_alu = '0;
   logic [DW-1:0]      wdata_alu = '0;
   logic               wen_alu = 1'b0;
   logic [DW-1:0]      rdata_vga;
   logic [AW-1:0]      raddr_alu;
   logic [DS*DW-1:0]   rdata_alu;

   mem_controller #(.AWIDTH(AW), .DWIDTH(DW), .DWSS(DS), .H_RES(HR), .V_RES(VR)) dut (
      .sys_clk(sys_clk), .rst(rst), .pclk(pclk), .vsync_cam(vsync_cam), .href_cam(href_cam),
      .wdata_cam(wdata_cam), .raddr_vga(raddr_vga), .rdata_vga(rdata_vga), .raddr_alu(raddr_alu),
      .waddr_alu(waddr_alu), .wdata_alu(wdata_alu), .wen_alu(wen_alu), .rdata_alu(rdata_alu));

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [AW-1:0]    a;
      logic [DS*DW-1:0] d;
      int               t;
   } exp_t;

   exp_t vga_q[$];
   exp_t win_q[$];
   int   n_tests = 0, n_fail = 0;
   int   cyc_cnt = 0;
   logic [1:0] tb_ph;
   int   a_model;
   int   mon_wa;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

   // reference slot counter and scan address: slot 0 is the first cycle after reset release
   always @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         tb_ph   <= 2'd0;
         a_model <= 0;
      end else begin
         tb_ph <= tb_ph + 2'd1;
         if (tb_ph == 2'd2) a_model <= (a_model == FRAME - 1) ? 0 : a_model + 1;
      end
   end

   // monitor: pops expectations when the DUT presents the matching output
   always @(negedge sys_clk) begin
      if (rst) begin
         if (vga_q.size() > 0 && cyc_cnt >= vga_q[0].t + 8) begin
            chk($sformatf("vga_rd[%0d]", vga_q[0].a), 64'(rdata_vga), 64'(vga_q[0].d[DW-1:0]));
            void'(vga_q.pop_front());
         end
         if (tb_ph == 2'd0 && win_q.size() > 0) begin
            mon_wa = (a_model == 0) ? FRAME - 1 : a_model - 1;
            if (mon_wa == int'(win_q[0].a)) begin
               chk($sformatf("alu_window[%0d]", win_q[0].a), 64'(rdata_alu), 64'(win_q[0].d));
               void'(win_q.pop_front());
            end
         end
         if (tb_ph == 2'd3 && (a_model == 0 || a_model == FRAME - 1 || a_model == 1281)) begin
            chk($sformatf("raddr_alu@%0d", a_model), 64'(raddr_alu), 64'(a_model));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      wdata_cam = b;
      pclk = 1'b0;
      cyc(2);
      pclk = 1'b1;
      cyc(2);
   endtask

   task automatic send_pixel(input logic [11:0] p);
      send_byte({4'h0, p[11:8]});
      send_byte(p[7:0]);
   endtask

   task automatic vsync_pulse();
      vsync_cam = 1'b1;
      cyc(6);
      vsync_cam = 1'b0;
      cyc(4);
   endtask

   task automatic alu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      waddr_alu = a;
      wdata_alu = d;
      wen_alu = 1'b1;
      cyc(1);
      wen_alu = 1'b0;
      cyc(8);
   endtask

   task automatic vga_check(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      int   n;
      cyc(8);
      raddr_vga = a;
      e.a = a;
      e.d = '0;
      e.d[DW-1:0] = d;
      e.t = cyc_cnt;
      vga_q.push_back(e);
      n = 0;
      while (vga_q.size() > 0 && n < 40) begin
         cyc(1);
         n++;
      end
      if (vga_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL vga_timeout: read of %0d still pending after %0d cycles", a, n);
         vga_q.delete();
      end
   endtask

   task automatic push_window(input logic [AW-1:0] a, input logic [DS*DW-1:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      e.t = cyc_cnt;
      win_q.push_back(e);
   endtask

   initial begin
      int n;
      // reset
      cyc(5);
      chk("reset_rdata_vga", 64'(rdata_vga), 64'h0);
      chk("reset_raddr_alu", 64'(raddr_alu), 64'h0);
      chk("reset_rdata_alu", 64'(rdata_alu), 64'h0);
      rst = 1'b1;
      cyc(2);

      // line 0: pixel value = address, then a stray byte before href drops
      vsync_pulse();
      href_cam = 1'b1;
      cyc(4);
      for (int i = 0; i < HR; i++) send_pixel(12'(i));
      send_byte(8'h5A);
      cyc(2);
      href_cam = 1'b0;
      cyc(8);
      // line 1 must not be skewed by the stray byte
      href_cam = 1'b1;
      cyc(4);
      for (int x = 0; x < HR; x++) send_pixel(12'(HR + x));
      href_cam = 1'b0;

      vga_check(19'd5,    12'h005);
      vga_check(19'd0,    12'h000);
      vga_check(19'd639,  12'h27F);
      vga_check(19'd640,  12'h280);
      vga_check(19'd641,  12'h281);
      vga_check(19'd1279, 12'h4FF);

      // row 2 seeds for the window, plus a plain ALU write
      alu_write(19'd1281, 12'h501);
      alu_write(19'd1282, 12'h502);
      alu_write(19'd2000, 12'h123);
      vga_check(19'd2000, 12'h123);

      // out-of-range VGA address must not stall the controller
      raddr_vga = '1;
      cyc(8);

      push_window(19'd1281, {12'h001, 12'h281, 12'h501});
      push_window(19'd1282, {12'h002, 12'h282, 12'h502});
      n = 0;
      while (win_q.size() > 0 && n < 25000) begin
         cyc(1);
         n++;
      end
      if (win_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL window_timeout: %0d windows never presented", win_q.size());
         win_q.delete();
      end

      // vsync mid-frame restarts the camera address
      href_cam = 1'b1;
      cyc(4);
      for (int i = 0; i < 100; i++) send_pixel(12'(12'h100 + i));
      cyc(8);
      vsync_cam = 1'b1;
      send_byte(8'hFF);
      cyc(4);
      vsync_cam = 1'b0;
      cyc(4);
      send_pixel(12'hABC);
      send_pixel(12'hABD);
      send_pixel(12'hABE);
      vga_check(19'd0,    12'hABC);
      vga_check(19'd1,    12'hABD);
      vga_check(19'd2,    12'hABE);
      vga_check(19'd1280, 12'h100);
      vga_check(19'd1379, 12'h163);

      // camera pixels 3..6, then pixel 7 racing an ALU write to the same address
      send_pixel(12'h333);
      send_pixel(12'h344);
      send_pixel(12'h355);
      send_pixel(12'h366);
      send_byte(8'h00);
      waddr_alu = 19'd7;
      wdata_alu = 12'hFFF;
      wen_alu = 1'b1;
      send_byte(8'hEE);
      cyc(10);
      wen_alu = 1'b0;
      href_cam = 1'b0;
      vga_check(19'd3, 12'h333);
      vga_check(19'd6, 12'h366);
      vga_check(19'd7, 12'hFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
